// File: rtl/cgra_clkgate_pkg.sv
// Shared types and defaults for the CGRA per-domain clock-gating controller.
package cgra_clkgate_pkg;

    typedef enum logic [1:0] {CG_OFF, CG_WAKE, CG_ON, CG_DRAIN} cg_state_e;

    localparam logic [7:0] CG_IDLE_THR_RST = 8'd16;
    localparam int         CG_IDLE_W_DEF   = 8;

endpackage

// File: rtl/cgra_clkgate_ctrl_if.sv
// Request/activity/config inputs and enable/ack/count outputs of the clock-gating controller.
interface cgra_clkgate_ctrl_if
    import cgra_clkgate_pkg::*;
#(
    parameter int N_DOM  = 4,
    parameter int IDLE_W = CG_IDLE_W_DEF
);
    logic [N_DOM-1:0]             req_i;
    logic [N_DOM-1:0]             busy_i;
    logic                         force_en_i;
    logic                         cfg_we_i;
    logic [IDLE_W-1:0]            cfg_idle_thr_i;
    logic [N_DOM-1:0]             en_o;
    logic [N_DOM-1:0]             ack_o;
    logic [$clog2(N_DOM+1)-1:0]   active_cnt_o;

    modport master (
        output req_i, busy_i, force_en_i, cfg_we_i, cfg_idle_thr_i,
        input  en_o, ack_o, active_cnt_o
    );

    modport slave (
        input  req_i, busy_i, force_en_i, cfg_we_i, cfg_idle_thr_i,
        output en_o, ack_o, active_cnt_o
    );
endinterface

// File: rtl/cgra_clkgate_dom_fsm.sv
// One gated domain: OFF/WAKE/ON/DRAIN sequencing with wake and idle counters.
module cgra_clkgate_dom_fsm
    import cgra_clkgate_pkg::*;
#(
    parameter int IDLE_W   = CG_IDLE_W_DEF,
    parameter int WAKE_CYC = 2
)(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              busy_i,
    input  logic              force_en_i,
    input  logic [IDLE_W-1:0] idle_thr_i,
    output logic              en_o,
    output logic              ack_o
);
    localparam int WW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

    cg_state_e         state_q;
    logic [WW-1:0]     wake_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              act;

    assign act = req_i | busy_i | force_en_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= CG_OFF;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            en_o       <= 1'b0;
            ack_o      <= 1'b0;
        end else begin
            unique case (state_q)
                CG_OFF: begin
                    if (req_i | force_en_i) begin
                        state_q    <= CG_WAKE;
                        en_o       <= 1'b1;
                        wake_cnt_q <= WW'(WAKE_CYC - 1);
                    end
                end
                // A request dropping here does not abort: the gate is already opening.
                CG_WAKE: begin
                    if (wake_cnt_q == '0) begin
                        state_q    <= CG_ON;
                        ack_o      <= 1'b1;
                        idle_cnt_q <= idle_thr_i;
                    end else begin
                        wake_cnt_q <= wake_cnt_q - 1'b1;
                    end
                end
                CG_ON: begin
                    if (act) idle_cnt_q <= idle_thr_i;
                    else     state_q    <= CG_DRAIN;
                end
                // Activity takes priority over expiry so a late pulse never loses the clock.
                CG_DRAIN: begin
                    if (act) begin
                        state_q    <= CG_ON;
                        idle_cnt_q <= idle_thr_i;
                    end else if (idle_cnt_q == IDLE_W'(1)) begin
                        state_q <= CG_OFF;
                        en_o    <= 1'b0;
                        ack_o   <= 1'b0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q - 1'b1;
                    end
                end
                default: state_q <= CG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/cgra_clkgate_ctrl.sv
// Clock-gating controller: idle threshold register, N_DOM domain FSMs and enable population count.
module cgra_clkgate_ctrl
    import cgra_clkgate_pkg::*;
#(
    parameter int N_DOM    = 4,
    parameter int IDLE_W   = CG_IDLE_W_DEF,
    parameter int WAKE_CYC = 2
)(
    input  logic               clk_i,
    input  logic               rst_ni,
    cgra_clkgate_ctrl_if.slave bus
);
    localparam int CW = $clog2(N_DOM + 1);

    logic [IDLE_W-1:0] idle_thr_q;
    logic [N_DOM-1:0]  en;
    logic [N_DOM-1:0]  ack;
    logic [CW-1:0]     cnt;

    // Zero is stored as 1 so a drain always lasts at least one countdown cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            idle_thr_q <= IDLE_W'(CG_IDLE_THR_RST);
        else if (bus.cfg_we_i)
            idle_thr_q <= (bus.cfg_idle_thr_i == '0) ? IDLE_W'(1) : bus.cfg_idle_thr_i;
    end

    for (genvar d = 0; d < N_DOM; d++) begin : g_dom
        cgra_clkgate_dom_fsm #(
            .IDLE_W   (IDLE_W),
            .WAKE_CYC (WAKE_CYC)
        ) u_fsm (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .req_i      (bus.req_i[d]),
            .busy_i     (bus.busy_i[d]),
            .force_en_i (bus.force_en_i),
            .idle_thr_i (idle_thr_q),
            .en_o       (en[d]),
            .ack_o      (ack[d])
        );
    end

    // Count is derived only from the enable flops, so it tracks en_o exactly and clears with reset.
    always_comb begin
        cnt = '0;
        for (int d = 0; d < N_DOM; d++) cnt = cnt + CW'(en[d]);
    end

    assign bus.en_o         = en;
    assign bus.ack_o        = ack;
    assign bus.active_cnt_o = cnt;

endmodule

// File: tb/tb_cgra_clkgate_ctrl.sv
// Directed bench for cgra_clkgate_ctrl: wake latency, idle timeout, collisions, force and async reset.
module tb_cgra_clkgate_ctrl;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    cgra_clkgate_ctrl_if #(.N_DOM(4), .IDLE_W(8)) ifc ();

    cgra_clkgate_ctrl #(.N_DOM(4), .IDLE_W(8), .WAKE_CYC(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [7:0] thr);
        ifc.cfg_idle_thr_i = thr;
        ifc.cfg_we_i       = 1'b1;
        tick();
        ifc.cfg_we_i       = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        ifc.req_i          = '0;
        ifc.busy_i         = '0;
        ifc.force_en_i     = 1'b0;
        ifc.cfg_we_i       = 1'b0;
        ifc.cfg_idle_thr_i = '0;
        tick(2);
        chk("rst_en",  32'(ifc.en_o), 32'h0);
        chk("rst_ack", 32'(ifc.ack_o), 32'h0);
        chk("rst_cnt", 32'(ifc.active_cnt_o), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", 32'({ifc.ack_o, ifc.en_o, ifc.active_cnt_o}), 32'h0);
        end

        // Wake latency on domain 0 with the reset threshold of 16.
        ifc.req_i = 4'b0001;
        tick();
        chk("wake_en",   32'(ifc.en_o), 32'h1);
        chk("wake_ack0", 32'(ifc.ack_o), 32'h0);
        chk("wake_cnt",  32'(ifc.active_cnt_o), 32'h1);
        tick();
        chk("wake_ack1", 32'(ifc.ack_o), 32'h0);
        tick();
        chk("wake_ack2", 32'(ifc.ack_o), 32'h1);
        chk("wake_en2",  32'(ifc.en_o), 32'h1);
        ifc.req_i = '0;
        tick(16);
        chk("thr16_hold", 32'(ifc.en_o), 32'h1);
        tick();
        chk("thr16_off", 32'(ifc.en_o), 32'h0);

        // Idle timeout with threshold 4 on domain 1.
        cfg(8'd4);
        ifc.req_i = 4'b0010;
        tick(10);
        chk("thr4_on_en",  32'(ifc.en_o), 32'h2);
        chk("thr4_on_ack", 32'(ifc.ack_o), 32'h2);
        ifc.req_i = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("thr4_hold", 32'({ifc.ack_o, ifc.en_o}), 32'h22);
        end
        tick();
        chk("thr4_off", 32'({ifc.ack_o, ifc.en_o}), 32'h0);
        chk("thr4_cnt", 32'(ifc.active_cnt_o), 32'h0);

        // Threshold 0 behaves as 1.
        cfg(8'd0);
        ifc.req_i = 4'b0010;
        tick(10);
        ifc.req_i = '0;
        tick();
        chk("thr0_hold", 32'(ifc.en_o), 32'h2);
        tick();
        chk("thr0_off", 32'({ifc.ack_o, ifc.en_o}), 32'h0);

        // Busy in the expiry cycle keeps domain 2 on, then a mid-drain pulse.
        cfg(8'd4);
        ifc.req_i = 4'b0100;
        tick(5);
        chk("col_ack", 32'(ifc.ack_o), 32'h4);
        ifc.req_i = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("col_drain", 32'(ifc.en_o), 32'h4);
        end
        ifc.busy_i = 4'b0100;
        tick();
        chk("col_expiry", 32'({ifc.ack_o, ifc.en_o}), 32'h44);
        ifc.busy_i = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mid_drain", 32'(ifc.en_o), 32'h4);
        end
        ifc.busy_i = 4'b0100;
        tick();
        chk("mid_pulse", 32'(ifc.en_o), 32'h4);
        ifc.busy_i = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_hold", 32'(ifc.en_o), 32'h4);
        end
        tick();
        chk("mid_off", 32'({ifc.ack_o, ifc.en_o}), 32'h0);

        // A one-cycle request still completes the wake.
        ifc.req_i = 4'b1000;
        tick();
        chk("pulse_en", 32'(ifc.en_o), 32'h8);
        ifc.req_i = '0;
        tick();
        chk("pulse_ack0", 32'(ifc.ack_o), 32'h0);
        tick();
        chk("pulse_ack", 32'({ifc.ack_o, ifc.en_o}), 32'h88);
        tick(4);
        chk("pulse_hold", 32'(ifc.en_o), 32'h8);
        tick();
        chk("pulse_off", 32'(ifc.en_o), 32'h0);

        // Force with every domain off.
        ifc.force_en_i = 1'b1;
        tick();
        chk("frc_en",   32'(ifc.en_o), 32'hF);
        chk("frc_cnt",  32'(ifc.active_cnt_o), 32'h4);
        chk("frc_ack0", 32'(ifc.ack_o), 32'h0);
        tick();
        chk("frc_ack1", 32'(ifc.ack_o), 32'h0);
        tick();
        chk("frc_ack2", 32'(ifc.ack_o), 32'hF);
        tick(2);
        ifc.force_en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("frc_drain", 32'(ifc.en_o), 32'hF);
        end
        tick();
        chk("frc_off",     32'(ifc.en_o), 32'h0);
        chk("frc_off_cnt", 32'(ifc.active_cnt_o), 32'h0);

        // Asynchronous reset while all domains drain.
        ifc.force_en_i = 1'b1;
        tick(4);
        ifc.force_en_i = 1'b0;
        tick(2);
        chk("pre_rst_en", 32'(ifc.en_o), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en",  32'(ifc.en_o), 32'h0);
        chk("arst_ack", 32'(ifc.ack_o), 32'h0);
        chk("arst_cnt", 32'(ifc.active_cnt_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
